// File: rtl/mult_arbiter_if.sv
// Handshake bundle between the multiplier arbiter, its requesters and the shared multiplier.
// Ports: requester side (req_*/rsp_*) and multiplier side (mul_*).
// master = arbiter view, slave = environment (requesters + multiplier) view.
interface mult_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 32
);
    logic [N-1:0]         req_valid;
    logic [N*WIDTH-1:0]   req_a;
    logic [N*WIDTH-1:0]   req_b;
    logic [N-1:0]         req_ready;
    logic [N-1:0]         rsp_valid;
    logic [2*WIDTH-1:0]   rsp_data;
    logic                 rsp_err;
    logic [N-1:0]         rsp_ack;
    logic [WIDTH-1:0]     mul_a;
    logic [WIDTH-1:0]     mul_b;
    logic                 mul_valid_data;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_result;
    logic                 mul_ack;

    modport master (
        input  req_valid, req_a, req_b, rsp_ack, mul_done, mul_result,
        output req_ready, rsp_valid, rsp_data, rsp_err,
               mul_a, mul_b, mul_valid_data, mul_ack
    );

    modport slave (
        output req_valid, req_a, req_b, rsp_ack, mul_done, mul_result,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
               mul_a, mul_b, mul_valid_data, mul_ack
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multiplier among N requesters, with a done-flag watchdog.
// Latency: grant+issue 1 cycle after request, response 1 cycle after mul_done, idle 2 cycles after rsp_ack.
// Backpressure: one transaction in flight; RESP holds until the granted requester acks.
// Ports: clk, rst_n (async active-low); bus = request/response/multiplier handshakes;
//        busy = not idle; grant_id = index of current or last grant.
module mult_arbiter #(
    parameter int N       = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 40
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_arbiter_if.master bus,
    output logic           busy,
    output logic [2:0]     grant_id
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, RELEASE} state_t;

    state_t             state, state_nxt;
    logic [2:0]         last_grant;
    logic [2:0]         pick;
    logic               pick_vld;
    logic [WIDTH-1:0]   pick_a, pick_b;
    logic [WIDTH-1:0]   op_a, op_b;
    logic [2*WIDTH-1:0] rsp_data_q;
    logic               rsp_err_q;
    logic [CW-1:0]      wdog;
    logic               wdog_exp;
    logic [N-1:0]       grant_oh;

    // Round-robin pick: first requester above last_grant, else the lowest set bit
    // (which puts last_grant itself at the bottom of the order).
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        pick_a   = '0;
        pick_b   = '0;
        for (int j = 0; j < N; j++) begin
            if (!pick_vld && bus.req_valid[j] && (3'(j) > last_grant)) begin
                pick     = 3'(j);
                pick_vld = 1'b1;
                pick_a   = bus.req_a[j*WIDTH +: WIDTH];
                pick_b   = bus.req_b[j*WIDTH +: WIDTH];
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!pick_vld && bus.req_valid[j]) begin
                pick     = 3'(j);
                pick_vld = 1'b1;
                pick_a   = bus.req_a[j*WIDTH +: WIDTH];
                pick_b   = bus.req_b[j*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        for (int j = 0; j < N; j++) begin
            if (3'(j) == grant_id) grant_oh[j] = 1'b1;
        end
    end

    assign wdog_exp = (wdog == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            // mul_done and watchdog expiry both leave WAIT; the datapath gives mul_done priority.
            WAIT:    if (bus.mul_done || wdog_exp) state_nxt = RESP;
            // Only the granted requester's ack counts.
            RESP:    if (|(bus.rsp_ack & grant_oh)) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 3'(N - 1);
            grant_id   <= '0;
            op_a       <= '0;
            op_b       <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            wdog       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        op_a       <= pick_a;
                        op_b       <= pick_b;
                        grant_id   <= pick;
                        last_grant <= pick;
                    end
                end
                ISSUE: wdog <= '0;
                WAIT: begin
                    if (bus.mul_done) begin
                        rsp_data_q <= bus.mul_result;
                        rsp_err_q  <= 1'b0;
                    end else if (wdog_exp) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // All outputs come from registers or a decode of the state register.
    assign bus.req_ready      = (state == ISSUE) ? grant_oh : '0;
    assign bus.mul_valid_data = (state == ISSUE);
    assign bus.rsp_valid      = (state == RESP) ? grant_oh : '0;
    assign bus.mul_ack        = (state == RELEASE);
    assign bus.rsp_data       = rsp_data_q;
    assign bus.rsp_err        = rsp_err_q;
    assign bus.mul_a          = op_a;
    assign bus.mul_b          = op_b;
    assign busy               = (state != IDLE);
endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter that shares one shift-add multiplier (FSM + datapath) among N requesters. Grants one request at a time, latches its operands, and drives the multiplier's valid_data/ack handshake. It returns the 2×WIDTH product to the granted requester through a valid/ack response handshake. A cycle watchdog guards against a multiplier that never raises its done flag.

## Interface
- N, default 4: number of requesters (2..8).
- WIDTH, default 32: operand width; product is 2*WIDTH.
- TIMEOUT, default 40: maximum WAIT cycles before error; must exceed WIDTH+2.

- Clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req_valid  in  N  per-requester request; held high until the matching req_ready pulse.
- req_a  in  N*WIDTH  packed operand a; slice k belongs to requester k.
- req_b  in  N*WIDTH  packed operand b; slice k belongs to requester k.
- req_ready  out  N  one-hot, one-cycle pulse: request accepted, operands latched.
- rsp_valid  out  N  one-hot: result for requester k is available.
- rsp_data  out  2*WIDTH  product; valid while any rsp_valid bit is high.
- rsp_err  out  1  set with rsp_valid when the watchdog expired.
- rsp_ack  in  N  requester k has consumed its response.
- mul_a, mul_b  out  WIDTH each  operands driven to the multiplier; held from ISSUE through RELEASE.
- mul_valid_data  out  1  start pulse to the multiplier.
- mul_done  in  1  multiplier's done flag.
- mul_result  in  2*WIDTH  multiplier product.
- mul_ack  out  1  result-read acknowledge to the multiplier.
- busy  out  1  high in every state except IDLE.
- grant_id  out  3  index of the current or last grant.

## Operation
- States: IDLE → ISSUE → WAIT → RESP → RELEASE → IDLE.
- IDLE:
  - If req_valid==0, stay in IDLE.
  - Otherwise pick the first set bit searching from (last_grant+1) mod N, upward with wrap.
  - Latch req_a/req_b slices into mul_a/mul_b; set grant_id and last_grant; go to ISSUE.
- ISSUE (1 cycle):
  - req_ready[grant_id]=1 and mul_valid_data=1.
  - Clear the watchdog counter; go to WAIT.
- WAIT:
  - mul_valid_data=0; the watchdog counter increments each cycle.
  - On mul_done=1: register mul_result into rsp_data, rsp_err=0, go to RESP.
  - On counter==TIMEOUT-1 with no mul_done: rsp_data=0, rsp_err=1, go to RESP.
  - If both occur in the same cycle, mul_done wins.
- RESP:
  - rsp_valid[grant_id]=1; hold rsp_data and rsp_err stable.
  - On rsp_ack[grant_id]=1, go to RELEASE.
  - rsp_ack bits of other requesters are ignored.
- RELEASE (1 cycle):
  - mul_ack=1; rsp_valid=0; go to IDLE.
- Withdrawing req_valid after the grant has no effect; requester k receives a response regardless.
- A requester granted last has the lowest priority next round, so no requester waits more than N-1 grants.
- Reset state and values:
  - State is IDLE and last_grant=N-1, so the first grant goes to requester 0 when it requests.
  - All outputs are 0: req_ready, rsp_valid, rsp_data, rsp_err, mul_a, mul_b, mul_valid_data, mul_ack, busy, grant_id.
- Reset mid-operation returns to IDLE immediately, with no response and no mul_ack. The multiplier shares the same reset.

## Timing
- Request sampled in IDLE at edge t → req_ready and mul_valid_data high during cycle t+1.
- mul_done sampled high at edge t → rsp_valid high from t+1.
- rsp_ack sampled at edge t → mul_ack high during cycle t+1 → IDLE at t+2.
- Earliest next grant: ISSUE at t+3.
- All outputs are registered or decoded from the state register only; no combinational path from inputs to outputs.
- Minimum turnaround per transaction: 5 cycles plus the multiplier's latency.

## Test plan
- Single request: requester 2 with a=7, b=6. Expect:
  - req_ready=0b0100 for one cycle, mul_valid_data in the same cycle.
  - rsp_data=42 with rsp_valid=0b0100, rsp_err=0.
  - mul_ack one cycle after rsp_ack.
- Simultaneous requests: req_valid=0b1111 held, back-to-back, right after reset. Expect grant order 0,1,2,3,0.
  - With a=k+1, b=3, rsp_data=3,6,9,12 in order.
- Fairness: requester 1 requests continuously while requester 3 requests once. Expect grants 1,3,1 (requester 3 not starved).
- Max operands: a=b=0xFFFFFFFF → rsp_data=0xFFFFFFFE00000001.
- Watchdog: mul_done tied to 0. Expect:
  - rsp_valid TIMEOUT cycles after ISSUE, rsp_data=0, rsp_err=1.
  - After rsp_ack, mul_ack pulse, then return to IDLE.
- Reset during WAIT: assert Reset low for 1 cycle. Expect:
  - All outputs 0 and busy=0.
  - Next request from requester 0 granted normally.
